// File: rtl/keypad_pkg.sv
// Shared constants, key map and debounce state type for the 4x4 keypad scanner.
package keypad_pkg;

  localparam logic [3:0] COL0   = 4'b0111;
  localparam logic [3:0] COL1   = 4'b1011;
  localparam logic [3:0] COL2   = 4'b1101;
  localparam logic [3:0] COL3   = 4'b1110;
  localparam logic [3:0] NO_ROW = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    PRESSED = 2'd2
  } db_state_e;

  function automatic logic [3:0] col_pattern(input logic [1:0] col_idx);
    case (col_idx)
      2'd0:    col_pattern = COL0;
      2'd1:    col_pattern = COL1;
      2'd2:    col_pattern = COL2;
      default: col_pattern = COL3;
    endcase
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    case ({row_idx, col_idx})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h2;
      4'h2: key_map = 4'h3;
      4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h6;
      4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;
      4'h9: key_map = 4'h8;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;
      4'hD: key_map = 4'h0;
      4'hE: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-scan debounce FSM: turns raw scan results into accepted presses and a held level.
//   state   | meaning
//   IDLE    | no key pressed
//   CAND    | candidate key seen, counting identical scans
//   PRESSED | key accepted, counting empty scans toward release
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_done,
  input  logic       scan_hit,
  input  logic [3:0] scan_code,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam bit ONE_SHOT = (DEBOUNCE_SCANS == 1);

  db_state_e        state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic             new_key;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  // A hit that differs from the tracked candidate restarts debouncing, including rollover from PRESSED.
  assign new_key = scan_hit && ((state_q == IDLE) || (scan_code != cand_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        if (new_key) begin
          cand_q <= scan_code;
          if (ONE_SHOT) begin
            state_q     <= PRESSED;
            cnt_q       <= '0;
            key_code_q  <= scan_code;
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
          end else begin
            state_q    <= CAND;
            cnt_q      <= CNT_W'(1);
            key_held_q <= 1'b0;
          end
        end else begin
          case (state_q)
            CAND: begin
              if (!scan_hit) begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end else if (cnt_inc == CNT_MAX) begin
                state_q     <= PRESSED;
                cnt_q       <= '0;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end
            PRESSED: begin
              if (scan_hit) begin
                cnt_q <= '0;
              end else if (cnt_inc == CNT_MAX) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, row sampling and per-scan accumulation feeding the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [3:0]       col_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       code_q, code_d;
  logic             multi_q;
  logic             tc;
  logic             samp_hit;
  logic             samp_multi;
  logic [1:0]       row_idx;
  logic             scan_done;
  logic             scan_hit;

  assign tc = (div_q == DIV_LAST);

  always_comb begin
    samp_hit = 1'b1;
    row_idx  = 2'd0;
    case (row)
      4'b0111: row_idx = 2'd0;
      4'b1011: row_idx = 2'd1;
      4'b1101: row_idx = 2'd2;
      4'b1110: row_idx = 2'd3;
      default: samp_hit = 1'b0;
    endcase
    samp_multi = !samp_hit && (row != NO_ROW);
  end

  // Hit count saturates at 2: anything beyond one key is reported the same way.
  always_comb begin
    hits_d = hits_q;
    code_d = code_q;
    if (samp_multi) begin
      hits_d = 2'd2;
    end else if (samp_hit) begin
      hits_d = (hits_q == 2'd0) ? 2'd1 : 2'd2;
      code_d = key_map(row_idx, col_idx_q);
    end
    scan_done = tc && (col_idx_q == 2'd3);
    scan_hit  = scan_done && (hits_d == 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      col_q     <= COL0;
      col_idx_q <= 2'd0;
      hits_q    <= 2'd0;
      code_q    <= 4'd0;
      multi_q   <= 1'b0;
    end else begin
      multi_q <= scan_done && (hits_d == 2'd2);
      if (tc) begin
        div_q     <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        col_q     <= col_pattern(col_idx_q + 2'd1);
        if (col_idx_q == 2'd3) begin
          hits_q <= 2'd0;
          code_q <= 4'd0;
        end else begin
          hits_q <= hits_d;
          code_q <= code_d;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_done(scan_done),
    .scan_hit (scan_hit),
    .scan_code(code_d),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  assign col       = col_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model drives rows from columns, a scan-level reference model predicts outputs.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 1;
  localparam int DB       = 2;
  localparam int KMAP[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  localparam logic [3:0] COLPAT[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held, multi_key;
  logic [15:0] pressed;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: scan position, scan key count, debounce state as plain integers
  int mcyc, m_count, m_scode, m_state, m_cand, m_cnt, m_code;
  bit m_valid, m_multi;
  int vlog[$];
  int multi_seen;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
  );

  // keypad: a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (col[3-c] == 1'b0)) row[3-r] = 1'b0;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, mcyc);
    end
  endtask

  task automatic model_reset();
    mcyc = 0; m_count = 0; m_scode = 0; m_state = 0; m_cand = 0; m_cnt = 0;
    m_code = 0; m_valid = 0; m_multi = 0;
  endtask

  task automatic accept();
    m_code  = m_cand;
    m_valid = 1;
    m_state = 2;
    m_cnt   = 0;
  endtask

  task automatic db_update(input bit hit, input int code);
    if (hit) begin
      if (m_state == 2 && code == m_cand) m_cnt = 0;
      else if (m_state == 1 && code == m_cand) begin
        m_cnt++;
        if (m_cnt >= DB) accept();
      end else begin
        m_cand = code; m_cnt = 1; m_state = 1;
        if (m_cnt >= DB) accept();
      end
    end else if (m_state == 2) begin
      m_cnt++;
      if (m_cnt >= DB) begin m_state = 0; m_cnt = 0; end
    end else begin
      m_state = 0; m_cnt = 0;
    end
  endtask

  // one clock: predict what the coming edge does, then compare all outputs after it
  task automatic step();
    int c, nlow, code;
    c = mcyc % 4;
    nlow = 0; code = 0;
    for (int r = 0; r < 4; r++)
      if (pressed[r*4+c]) begin nlow++; code = KMAP[r*4+c]; end
    m_count += nlow;
    if (nlow == 1) m_scode = code;
    m_valid = 0; m_multi = 0;
    if (c == 3) begin
      m_multi = (m_count >= 2);
      db_update(m_count == 1, m_scode);
      m_count = 0;
    end
    @(posedge clk); #1;
    mcyc++;
    check_eq("col", int'(col), int'(COLPAT[mcyc % 4]));
    check_eq("key_valid", int'(key_valid), int'(m_valid));
    check_eq("key_code", int'(key_code), m_code);
    check_eq("key_held", int'(key_held), int'(m_state == 2));
    check_eq("multi_key", int'(multi_key), int'(m_multi));
    if (key_valid) vlog.push_back(int'(key_code));
    if (multi_key) multi_seen++;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_col"}, int'(col), 4'b0111);
    check_eq({tag, "_code"}, int'(key_code), 0);
    check_eq({tag, "_valid"}, int'(key_valid), 0);
    check_eq({tag, "_held"}, int'(key_held), 0);
    check_eq({tag, "_multi"}, int'(multi_key), 0);
  endtask

  initial begin
    int lat, rel, kind, dur;
    int exp3[3];
    pressed = '0;
    rst_n = 1'b0;
    model_reset();
    multi_seen = 0;

    // 1: reset values and column rotation
    #12;
    check_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1;
    hold(4);

    // 2: key 5 held 20 cycles
    vlog.delete();
    pressed[5] = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (key_valid && lat == 0) lat = i + 1;
    end
    pressed = '0;
    rel = 99;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!key_held) begin rel = i + 1; break; end
    end
    check_eq("t2_pulses", vlog.size(), 1);
    if (vlog.size() > 0) check_eq("t2_code", vlog[0], 5);
    check_eq("t2_latency_ok", int'(lat >= 1 && lat <= 13), 1);
    check_eq("t2_release_ok", int'(rel <= 13), 1);
    hold(12);

    // 3: 1 -> 2 -> 3 back to back
    vlog.delete();
    exp3 = '{1, 2, 3};
    pressed = 16'h0001; hold(20);
    pressed = 16'h0002; hold(20);
    pressed = 16'h0004; hold(20);
    pressed = '0; hold(16);
    check_eq("t3_pulses", vlog.size(), 3);
    for (int i = 0; i < 3 && i < vlog.size(); i++) check_eq("t3_code", vlog[i], exp3[i]);

    // 4: single-scan bounce of key 3
    vlog.delete();
    pressed[2] = 1'b1; hold(4);
    pressed = '0; hold(16);
    check_eq("t4_pulses", vlog.size(), 0);
    check_eq("t4_code_kept", int'(key_code), 3);

    // 5: keys 1 and 5 together
    vlog.delete();
    multi_seen = 0;
    pressed = 16'h0021; hold(20);
    pressed = '0; hold(16);
    check_eq("t5_pulses", vlog.size(), 0);
    check_eq("t5_multi_ok", int'(multi_seen >= 4), 1);

    // 6: row 3 mapping, then reset while D held
    vlog.delete();
    exp3 = '{0, 15, 13};
    pressed = 16'h2000; hold(20); pressed = '0; hold(16);
    pressed = 16'h4000; hold(20); pressed = '0; hold(16);
    pressed = 16'h8000; hold(20); pressed = '0; hold(16);
    check_eq("t6_pulses", vlog.size(), 3);
    for (int i = 0; i < 3 && i < vlog.size(); i++) check_eq("t6_code", vlog[i], exp3[i]);
    pressed = 16'h8000; hold(20);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    vlog.delete();
    hold(20);
    check_eq("t6_repress_pulses", vlog.size(), 1);
    if (vlog.size() > 0) check_eq("t6_repress_code", vlog[0], 13);
    pressed = '0; hold(16);

    // random key activity against the model
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      dur  = $urandom_range(1, 24);
      pressed = '0;
      if (kind == 1 || kind == 2) pressed[$urandom_range(0, 15)] = 1'b1;
      if (kind == 3) begin
        pressed[$urandom_range(0, 15)] = 1'b1;
        pressed[$urandom_range(0, 15)] = 1'b1;
      end
      hold(dur);
    end
    pressed = '0; hold(16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Active 4x4 matrix-keypad scanner for the password-lock datapath. It drives the column lines one at a time, active-low, and samples the active-low row lines. It debounces the result and emits a registered 4-bit key code with a one-cycle valid pulse per accepted press. It is the driving end of the `col`/`row` keypad interface and feeds `keyboard_num` and the password-entry FSM in `top`.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is held low (dwell); must be ≥1.
- `DEBOUNCE_SCANS`, default 3: consecutive identical full-scan results required to accept a press or a release; must be ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `row`  in  4  keypad rows, active-low. `row[3]` is row 0 (pattern 0111), down to `row[0]` for row 3 (1110).
- `col`  out  4  column drive, exactly one bit low. Pattern 0111 = column 0 … 1110 = column 3.
- `key_code`  out  4  last accepted key, held until the next accept.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `key_held`  out  1  level, high while the accepted key remains pressed.
- `multi_key`  out  1  one-cycle pulse at the end of any scan that found more than one key.

## Operation
- Key map as [row][col0..col3]:
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E, 0, F, D
- Column drive:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count (tc), `col` rotates right (0111→1011→1101→1110→0111) and the column index increments mod 4.
- Sampling:
  - `row` is sampled only on the tc cycle, the last cycle of the dwell, which allows line settling.
  - Each sample with exactly one low row records a candidate code and increments a per-scan hit count.
  - A sample with two or more low rows counts as a multi-hit.
- Scan result: evaluated on the tc cycle of column 3.
  - hit = exactly one key in the scan, with its code.
  - none = zero keys.
  - Multiple keys count as none and pulse `multi_key`.
  - Scan accumulators clear for the next scan.
- Debounce FSM, evaluated once per scan result. Counter `cnt` saturates at DEBOUNCE_SCANS.
  - IDLE:
    - hit(k) → CAND, cand=k, cnt=1.
    - If DEBOUNCE_SCANS=1, accept immediately and go to PRESSED.
  - CAND:
    - hit(cand) → cnt+1; on reaching DEBOUNCE_SCANS, accept and go to PRESSED.
    - hit(other) → cand=other, cnt=1.
    - none → IDLE.
  - PRESSED:
    - hit(cand) → cnt=0.
    - none → cnt+1; on reaching DEBOUNCE_SCANS → IDLE.
    - hit(other) → CAND, cand=other, cnt=1. This rollover allows a new press without a full release.
  - Accept action: `key_code`←cand, `key_valid` pulses.
- `key_held` = (state==PRESSED).

## Timing
- Reset values: `col`=0111, `key_code`=0, `key_valid`=0, `key_held`=0, `multi_key`=0. Divider, column index, accumulators and `cnt` = 0. FSM = IDLE.
- Asserting `rst_n` mid-scan or mid-press aborts immediately. A key still held after release from reset must be re-debounced, then pulse again.
- All outputs are registered.
- `key_valid` and `multi_key` rise the cycle after the column-3 tc that produced the decision.
- `key_code` updates in the same cycle as `key_valid`.
- Press latency from a stable key ≤ (DEBOUNCE_SCANS+1)·4·SCAN_DIV+1 cycles.
- Release latency ≤ same bound.
- Counter widths:
  - Divider: max(1,$clog2(SCAN_DIV)).
  - `cnt`: $clog2(DEBOUNCE_SCANS+1).
  - Per-scan hit count saturates at 2.
- SCAN_DIV=1: `col` rotates every cycle and every cycle is a tc.

## Structure
- Shared package `keypad_pkg` holds:
  - the column patterns COL0..COL3;
  - the NO_ROW=4'b1111 constant;
  - the key-map function (row idx, col idx)→code;
  - the debounce state enum {IDLE, CAND, PRESSED}.
- One sub-module, `keypad_debounce`, holds the FSM and `cnt`. Its inputs are scan_done, scan_hit and scan_code; its outputs are key_code, key_valid and key_held.
- The scanner top holds the divider, column rotation and accumulators.

## Test plan
All scenarios use SCAN_DIV=1, DEBOUNCE_SCANS=2 and a behavioural keypad model that drives `row` from `col`.
1. Reset:
   - `rst_n`=0 → `col`=0111, `key_code`=0, `key_valid`=`key_held`=`multi_key`=0.
   - After release, `col` sequence is 1011, 1101, 1110, 0111 on successive cycles.
2. Hold key 5 for 20 cycles:
   - Exactly one `key_valid`, with `key_code`=5, within 13 cycles.
   - `key_held` stays high until ≤13 cycles after release.
3. Keys 1→2→3 back-to-back, no gap, 20 cycles each → three pulses carrying 1, 2, 3 in order.
4. Bounce: key 3 present for a single scan (4 cycles) → no `key_valid`, `key_code` unchanged.
5. Keys 1 and 5 held together for 20 cycles → `multi_key` pulses every scan, no `key_valid`.
6. Mapping and reset:
   - row3/col1, row3/col2 and row3/col3, each held 20 cycles → codes 0, F, D.
   - `rst_n` pulsed while D is held → outputs clear, then a fresh `key_valid` with code D.
